// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: IDLE/RUN/DONE sequencer, step counter and A/Q/L/M datapath.
// Optional macro BOOTH_UNSIGNED_EN adds the op_unsigned port for MULTU, which widens Q by one bit and runs one extra step.
module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
`ifdef BOOTH_UNSIGNED_EN
  input  logic             op_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

`ifdef BOOTH_UNSIGNED_EN
  localparam int QW = WIDTH + 1;
`else
  localparam int QW = WIDTH;
`endif
  localparam logic [CNT_W-1:0] NSTEP_C = CNT_W'(QW);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH:0]   r_a;
  logic [QW-1:0]    r_q;
  logic             r_l;
  logic [WIDTH:0]   r_m;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic             w_finish;
  logic             w_ext_m;
  logic [QW-1:0]    w_q_init;
  logic [WIDTH:0]   w_a_sum;
  logic [WIDTH:0]   w_a_nxt;
  logic [QW-1:0]    w_q_nxt;
  logic [2*WIDTH-1:0] w_prod;

`ifdef BOOTH_UNSIGNED_EN
  // MULTU extends both operands with zero, MULT with their sign bits.
  assign w_ext_m  = ~op_unsigned & mcand[WIDTH-1];
  assign w_q_init = {~op_unsigned & mplier[WIDTH-1], mplier};
`else
  assign w_ext_m  = mcand[WIDTH-1];
  assign w_q_init = mplier;
`endif

  assign w_last   = (r_cnt == CNT_W'(1));
  assign w_finish = w_step & w_last;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end
      end
      S_RUN: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (w_last) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Booth recoding of {Q[0],L}: 01 adds M, 10 subtracts M, 00/11 leave A alone.
  always_comb begin
    w_a_sum = r_a;
    unique case ({r_q[0], r_l})
      2'b01:   w_a_sum = r_a + r_m;
      2'b10:   w_a_sum = r_a - r_m;
      default: w_a_sum = r_a;
    endcase
  end

  assign w_a_nxt = {w_a_sum[WIDTH], w_a_sum[WIDTH:1]};
  assign w_q_nxt = {w_a_sum[0], r_q[QW-1:1]};

  // After the final shift the whole product sits in {A,Q}; keep its low 2*WIDTH bits.
`ifdef BOOTH_UNSIGNED_EN
  assign w_prod = {w_a_nxt[WIDTH-2:0], w_q_nxt};
`else
  assign w_prod = {w_a_nxt[WIDTH-1:0], w_q_nxt};
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_q   <= '0;
      r_l   <= 1'b0;
      r_m   <= '0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (w_load) begin
        r_a   <= '0;
        r_q   <= w_q_init;
        r_l   <= 1'b0;
        r_m   <= {w_ext_m, mcand};
        r_cnt <= NSTEP_C;
      end else if (w_step) begin
        r_a   <= w_a_nxt;
        r_q   <= w_q_nxt;
        r_l   <= r_q[0];
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_finish) begin
        r_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_lo <= w_prod[WIDTH-1:0];
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: table of directed signed products plus flush, reset,
// start-while-busy and back-to-back sequences; the MULTU cases run only with BOOTH_UNSIGNED_EN.
module tb_booth_mult_seq;

`ifdef BOOTH_UNSIGNED_EN
  localparam int NSTEP = 33;
`else
  localparam int NSTEP = 32;
`endif
  localparam int LIMIT = 200;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        op_u;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  booth_mult_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .flush      (flush),
    .mcand      (mcand),
    .mplier     (mplier),
`ifdef BOOTH_UNSIGNED_EN
    .op_unsigned(op_u),
`endif
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Launch one multiply and count edges after the start edge until done (bounded).
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, output int lat);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    lat    = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      tick();
      lat++;
    end
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    check(name, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    int lat;

    vecs[0] = '{32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[2] = '{32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000};
    vecs[3] = '{32'd0,        32'h12345678, 32'h00000000, 32'h00000000};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[5] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[6] = '{32'd12345,    32'd1000,     32'h00000000, 32'h00BC5EA8};
    vecs[7] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000};
    vecs[8] = '{32'hFFFF0000, 32'h00010000, 32'hFFFFFFFF, 32'h00000000};
    vecs[9] = '{32'h55555555, 32'd2,        32'h00000000, 32'hAAAAAAAA};

    rst    = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    mcand  = '0;
    mplier = '0;
    op_u   = 1'b0;
    tick();
    tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    rst = 1'b0;
    tick();

    // Directed signed products.
    for (int i = 0; i < 10; i++) begin
      run_mult(vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(NSTEP));
      check($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
      check($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
      tick();
      check($sformatf("v%0d_pulse", i), {62'd0, done, busy}, 64'd0);
    end

    // Flush at RUN cycle 10: back to idle, no done, previous result kept.
    mcand  = 32'd5;
    mplier = 32'd6;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check("fl_busy_run", {63'd0, busy}, 64'd1);
    for (int k = 0; k < 9; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_busy", {63'd0, busy}, 64'd0);
    check("fl_done", {63'd0, done}, 64'd0);
    check("fl_hold", {hi, lo}, {32'h00000000, 32'hAAAAAAAA});
    watch_no_done("fl_no_done", 40);
    run_mult(32'd5, 32'd6, lat);
    check("fl_re_lat", 64'(lat), 64'(NSTEP));
    check("fl_re_prod", {hi, lo}, 64'd30);
    tick();

    // Start pulses and operand changes while busy are ignored.
    mcand  = 32'd3;
    mplier = 32'd4;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    lat    = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      start = (lat == 3 || lat == 10);
      if (start) begin
        mcand  = 32'd99;
        mplier = 32'd99;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check("bb_lat1", 64'(lat), 64'(NSTEP));
    check("bb_prod1", {hi, lo}, 64'd12);

    // Back-to-back launch from DONE, with flush asserted alongside start.
    mcand  = 32'hFFFFFFFB;
    mplier = 32'd9;
    start  = 1'b1;
    flush  = 1'b1;
    tick();
    start  = 1'b0;
    flush  = 1'b0;
    check("bb_busy", {63'd0, busy}, 64'd1);
    check("bb_done_low", {63'd0, done}, 64'd0);
    lat = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      tick();
      lat++;
    end
    check("bb_lat2", 64'(lat), 64'(NSTEP));
    check("bb_prod2", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFD3});
    tick();

    // Reset at RUN cycle 15 clears everything and suppresses done.
    mcand  = 32'd7;
    mplier = 32'hFFFFFFFD;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_busy", {63'd0, busy}, 64'd0);
    check("mr_done", {63'd0, done}, 64'd0);
    check("mr_prod", {hi, lo}, 64'd0);
    watch_no_done("mr_no_done", 40);

`ifdef BOOTH_UNSIGNED_EN
    op_u = 1'b1;
    run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    check("u_lat", 64'(lat), 64'd33);
    check("u_prod", {hi, lo}, {32'hFFFFFFFE, 32'h00000001});
    tick();
    op_u = 1'b0;
    run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    check("s_lat", 64'(lat), 64'd33);
    check("s_prod", {hi, lo}, {32'h00000000, 32'h00000001});
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
